// File: rtl/mem_stage_pkg.sv
// Shared types, op IDs and helpers for the RV32I memory stage.
package mem_stage_pkg;

    localparam int unsigned DBITS   = 32;
    localparam int unsigned IOPBITS = 5;
    localparam int unsigned REGBITS = 5;
    localparam int unsigned IBITS   = 32;

    localparam logic [IOPBITS-1:0] OP_ADD = 5'h00;
    localparam logic [IOPBITS-1:0] OP_LB  = 5'h10;
    localparam logic [IOPBITS-1:0] OP_LH  = 5'h11;
    localparam logic [IOPBITS-1:0] OP_LW  = 5'h12;
    localparam logic [IOPBITS-1:0] OP_LBU = 5'h13;
    localparam logic [IOPBITS-1:0] OP_LHU = 5'h14;
    localparam logic [IOPBITS-1:0] OP_SB  = 5'h15;
    localparam logic [IOPBITS-1:0] OP_SH  = 5'h16;
    localparam logic [IOPBITS-1:0] OP_SW  = 5'h17;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    // Instruction fields held while an access is outstanding
    typedef struct packed {
        logic [IOPBITS-1:0] op;
        logic [DBITS-1:0]   addr;
        logic [DBITS-1:0]   store_data;
        logic [REGBITS-1:0] reg_dest;
        logic               wr_reg;
        logic [DBITS-1:0]   pc;
        logic [IBITS-1:0]   inst;
    } mem_hold_t;

    // MEM -> WB latch payload
    typedef struct packed {
        logic               valid;
        logic               wr_reg;
        logic               exc;
        logic [REGBITS-1:0] reg_dest;
        logic [DBITS-1:0]   data;
        logic [DBITS-1:0]   pc;
        logic [IBITS-1:0]   inst;
    } mem_latch_t;

    function automatic logic is_load(input logic [IOPBITS-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [IOPBITS-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [IOPBITS-1:0] op,
                                           input logic [1:0]         lane);
        logic mis;
        mis = 1'b0;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) begin
            mis = lane[0];
        end else if ((op == OP_LW) || (op == OP_SW)) begin
            mis = |lane;
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic: store strobes/replicated wdata and load extract/extend.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [IOPBITS-1:0] op_i,
    input  logic [1:0]         lane_i,
    input  logic [DBITS-1:0]   store_data_i,
    input  logic [DBITS-1:0]   rdata_i,
    output logic [3:0]         wstrb_o,
    output logic [DBITS-1:0]   wdata_o,
    output logic [DBITS-1:0]   load_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = rdata_i[{lane_i, 3'b000} +: 8];
        half_v      = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wstrb_o     = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;

        case (op_i)
            OP_SB: begin
                wstrb_o = 4'b0001 << lane_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            OP_SH: begin
                wstrb_o = 4'b0011 << lane_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            OP_SW: wstrb_o = 4'b1111;
            default: ;
        endcase

        case (op_i)
            OP_LB:  load_data_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU: load_data_o = {24'h000000, byte_v};
            OP_LH:  load_data_o = {{16{half_v[15]}}, half_v};
            OP_LHU: load_data_o = {16'h0000, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: variable-latency load/store with stall, MEM latch and forwarding.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [IOPBITS-1:0] in_op,
    input  logic [DBITS-1:0]   in_result,
    input  logic [DBITS-1:0]   in_store_data,
    input  logic [REGBITS-1:0] in_reg_dest,
    input  logic               in_wr_reg,
    input  logic [DBITS-1:0]   in_pc,
    input  logic [IBITS-1:0]   in_inst,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DBITS-1:0]   dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic [3:0]         dmem_wstrb,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic               mem_stall,
    output logic               wb_valid,
    output logic               wb_wr_reg,
    output logic               wb_exc,
    output logic [REGBITS-1:0] wb_reg_dest,
    output logic [DBITS-1:0]   wb_data,
    output logic [DBITS-1:0]   wb_pc,
    output logic [IBITS-1:0]   wb_inst,
    output logic               fwd_valid,
    output logic [REGBITS-1:0] fwd_reg,
    output logic [DBITS-1:0]   fwd_data
);

    mem_state_e state_q, state_d;
    mem_hold_t  hold_q, hold_d;
    mem_latch_t latch_q, latch_d;

    mem_hold_t  in_hold;
    mem_hold_t  sel;
    mem_latch_t done_c;
    logic       in_mem;
    logic       in_mis;
    logic       start_c;
    logic       req_c;
    logic       we_c;
    logic [3:0]       strb_c;
    logic [DBITS-1:0] wdata_c;
    logic [DBITS-1:0] load_data_c;

    // Current instruction, or the held one while waiting on memory
    always_comb begin
        in_hold.op         = in_op;
        in_hold.addr       = in_result;
        in_hold.store_data = in_store_data;
        in_hold.reg_dest   = in_reg_dest;
        in_hold.wr_reg     = in_wr_reg;
        in_hold.pc         = in_pc;
        in_hold.inst       = in_inst;
        sel     = (state_q == S_WAIT) ? hold_q : in_hold;
        in_mem  = is_load(in_op) || is_store(in_op);
        in_mis  = is_misaligned(in_op, in_result[1:0]);
        start_c = in_valid && in_mem && !in_mis;
    end

    mem_align u_align (
        .op_i         (sel.op),
        .lane_i       (sel.addr[1:0]),
        .store_data_i (sel.store_data),
        .rdata_i      (dmem_rdata),
        .wstrb_o      (strb_c),
        .wdata_o      (wdata_c),
        .load_data_o  (load_data_c)
    );

    always_comb begin
        req_c      = !reset && ((state_q == S_WAIT) || start_c);
        we_c       = req_c && is_store(sel.op);
        dmem_req   = req_c;
        dmem_we    = we_c;
        dmem_addr  = req_c ? {sel.addr[DBITS-1:2], 2'b00} : '0;
        dmem_wdata = we_c ? wdata_c : '0;
        dmem_wstrb = we_c ? strb_c : 4'b0000;
        mem_stall  = req_c && !dmem_ack;
    end

    // Latch contents for an access that completes this cycle
    always_comb begin
        done_c          = '0;
        done_c.valid    = 1'b1;
        done_c.wr_reg   = is_load(sel.op) && sel.wr_reg && (sel.reg_dest != '0);
        done_c.reg_dest = sel.reg_dest;
        done_c.data     = is_load(sel.op) ? load_data_c : sel.addr;
        done_c.pc       = sel.pc;
        done_c.inst     = sel.inst;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        latch_d = '0;
        case (state_q)
            S_IDLE: begin
                hold_d = in_hold;
                if (in_valid && in_mem && in_mis) begin
                    latch_d.valid    = 1'b1;
                    latch_d.exc      = 1'b1;
                    latch_d.reg_dest = in_reg_dest;
                    latch_d.data     = in_result;
                    latch_d.pc       = in_pc;
                    latch_d.inst     = in_inst;
                end else if (start_c) begin
                    if (dmem_ack) begin
                        latch_d = done_c;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    latch_d.valid    = in_valid;
                    latch_d.wr_reg   = in_wr_reg && (in_reg_dest != '0);
                    latch_d.reg_dest = in_reg_dest;
                    latch_d.data     = in_result;
                    latch_d.pc       = in_pc;
                    latch_d.inst     = in_inst;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    latch_d = done_c;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        wb_valid    = latch_q.valid;
        wb_wr_reg   = latch_q.wr_reg;
        wb_exc      = latch_q.exc;
        wb_reg_dest = latch_q.reg_dest;
        wb_data     = latch_q.data;
        wb_pc       = latch_q.pc;
        wb_inst     = latch_q.inst;
        fwd_valid   = latch_q.valid && latch_q.wr_reg && !latch_q.exc;
        fwd_reg     = latch_q.reg_dest;
        fwd_data    = latch_q.data;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage: zero-wait table plus wait-state and reset sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_op;
    logic [31:0] in_result, in_store_data, in_pc, in_inst;
    logic [4:0]  in_reg_dest;
    logic        in_wr_reg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall;
    logic        wb_valid, wb_wr_reg, wb_exc, fwd_valid;
    logic [4:0]  wb_reg_dest, fwd_reg;
    logic [31:0] wb_data, wb_pc, wb_inst, fwd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_op(in_op), .in_result(in_result),
        .in_store_data(in_store_data), .in_reg_dest(in_reg_dest),
        .in_wr_reg(in_wr_reg), .in_pc(in_pc), .in_inst(in_inst),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_wr_reg(wb_wr_reg), .wb_exc(wb_exc),
        .wb_reg_dest(wb_reg_dest), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_inst(wb_inst), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] result;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        wr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_valid;
        logic        e_wr;
        logic        e_exc;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] dest, input logic wr,
                         input logic ack, input logic [31:0] rdata);
        in_valid      = v;
        in_op         = op;
        in_result     = res;
        in_store_data = sd;
        in_reg_dest   = dest;
        in_wr_reg     = wr;
        dmem_ack      = ack;
        dmem_rdata    = rdata;
    endtask

    initial begin
        vecs[0]  = '{1'b1, OP_ADD, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b1, 32'hFFFF_FFFF,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_1234};
        vecs[1]  = '{1'b1, OP_LW, 32'h100, 32'h0, 5'd6, 1'b1, 1'b1, 32'hDEAD_BEEF,
                     1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, OP_LB, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 32'h8011_2233,
                     1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, OP_LBU, 32'h101, 32'h0, 5'd8, 1'b1, 1'b1, 32'h0000_F100,
                     1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_00F1};
        vecs[4]  = '{1'b1, OP_LH, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 32'h8001_1234,
                     1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFF_8001};
        vecs[5]  = '{1'b1, OP_LHU, 32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 32'h8001_F234,
                     1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_F234};
        vecs[6]  = '{1'b1, OP_SB, 32'h201, 32'h1234_56AB, 5'd11, 1'b1, 1'b1, 32'h0,
                     1'b1, 1'b1, 32'h200, 4'b0010, 32'hABAB_ABAB, 1'b1, 1'b0, 1'b0, 32'h201};
        vecs[7]  = '{1'b1, OP_SH, 32'h202, 32'h0000_ABCD, 5'd12, 1'b1, 1'b1, 32'h0,
                     1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 1'b0, 32'h202};
        vecs[8]  = '{1'b1, OP_SW, 32'h204, 32'hCAFE_F00D, 5'd13, 1'b1, 1'b1, 32'h0,
                     1'b1, 1'b1, 32'h204, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h204};
        vecs[9]  = '{1'b1, OP_LW, 32'h101, 32'h0, 5'd14, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h101};
        vecs[10] = '{1'b1, OP_LH, 32'h103, 32'h0, 5'd15, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h103};
        vecs[11] = '{1'b1, OP_SW, 32'h202, 32'h1111_2222, 5'd16, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h202};
        vecs[12] = '{1'b1, OP_LW, 32'h10, 32'h0, 5'd0, 1'b1, 1'b1, 32'h0000_0055,
                     1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0055};
        vecs[13] = '{1'b0, OP_ADD, 32'h77, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h77};
        vecs[14] = '{1'b0, OP_LW, 32'h100, 32'h0, 5'd4, 1'b0, 1'b1, 32'h1234_5678,
                     1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100};

        // Reset held with a valid load presented: everything stays quiet
        reset   = 1'b1;
        in_pc   = 32'h0;
        in_inst = 32'h0;
        drive(1'b1, OP_LW, 32'h100, 32'h0, 5'd1, 1'b1, 1'b0, 32'h0);
        #2;
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst mem_stall", 32'(mem_stall), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst fwd_valid", 32'(fwd_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].op, vecs[i].result, vecs[i].sd,
                  vecs[i].dest, vecs[i].wr, vecs[i].ack, vecs[i].rdata);
            in_pc   = 32'h1000 + 32'(i * 4);
            in_inst = 32'(i);
            #1;
            chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d dmem_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_wstrb));
            chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d mem_stall", i), 32'(mem_stall), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d wb_wr_reg", i), 32'(wb_wr_reg), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d wb_exc", i), 32'(wb_exc), 32'(vecs[i].e_exc));
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_data);
            chk($sformatf("v%0d wb_reg_dest", i), 32'(wb_reg_dest), 32'(vecs[i].dest));
            chk($sformatf("v%0d wb_pc", i), wb_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d fwd_valid", i), 32'(fwd_valid),
                32'(vecs[i].e_valid & vecs[i].e_wr & ~vecs[i].e_exc));
            chk($sformatf("v%0d fwd_reg", i), 32'(fwd_reg), 32'(vecs[i].dest));
            chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].e_data);
        end

        // LB at 0x103 with two wait cycles; inputs are scrambled while waiting
        @(negedge clk);
        in_pc = 32'h2000;
        drive(1'b1, OP_LB, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
        #1;
        chk("lbw c0 req", 32'(dmem_req), 32'd1);
        chk("lbw c0 stall", 32'(mem_stall), 32'd1);
        chk("lbw c0 addr", dmem_addr, 32'h100);
        @(posedge clk); #1;
        chk("lbw bubble0", 32'(wb_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, OP_SW, 32'h0000_0FFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 1'b0, 32'h0);
        #1;
        chk("lbw c1 stall", 32'(mem_stall), 32'd1);
        chk("lbw c1 addr", dmem_addr, 32'h100);
        chk("lbw c1 we", 32'(dmem_we), 32'd0);
        @(posedge clk); #1;
        chk("lbw bubble1", 32'(wb_valid), 32'd0);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8012_3456;
        #1;
        chk("lbw ack stall", 32'(mem_stall), 32'd0);
        chk("lbw ack req", 32'(dmem_req), 32'd1);
        chk("lbw ack addr", dmem_addr, 32'h100);
        @(posedge clk); #1;
        chk("lbw wb_valid", 32'(wb_valid), 32'd1);
        chk("lbw wb_data", wb_data, 32'hFFFF_FF80);
        chk("lbw wb_reg_dest", 32'(wb_reg_dest), 32'd7);
        chk("lbw wb_pc", wb_pc, 32'h2000);
        chk("lbw fwd_valid", 32'(fwd_valid), 32'd1);

        // Reset while waiting abandons the access
        @(negedge clk);
        drive(1'b1, OP_LW, 32'h300, 32'h0, 5'd2, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rw wait stall", 32'(mem_stall), 32'd1);
        chk("rw wait addr", dmem_addr, 32'h300);
        #1 reset = 1'b1;
        #1;
        chk("rw rst req", 32'(dmem_req), 32'd0);
        chk("rw rst stall", 32'(mem_stall), 32'd0);
        chk("rw rst wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rw post req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("rw post wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, OP_LW, 32'h400, 32'h0, 5'd3, 1'b1, 1'b1, 32'h1234_5678);
        #1;
        chk("rw fresh req", 32'(dmem_req), 32'd1);
        chk("rw fresh addr", dmem_addr, 32'h400);
        @(posedge clk); #1;
        chk("rw fresh wb_valid", 32'(wb_valid), 32'd1);
        chk("rw fresh wb_data", wb_data, 32'h1234_5678);
        chk("rw fresh fwd_reg", 32'(fwd_reg), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the five-stage RV32I pipeline. It sits between the AGEX latch and the WB stage and consumes the ALU result or effective address produced by AGEX. It performs loads and stores against a variable-latency data-memory port and stalls AGEX/DE while an access is outstanding. It registers results into the MEM latch for WB and exports forwarding info for the instruction held in that latch.

Parameters:
DBITS, 32, datapath/address width
IOPBITS, `IOPBITS from define.vh, opcode-ID width
REGBITS, 5, register index width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  AGEX latch holds a real instruction
in_op  in  IOPBITS  decoded op ID
in_result  in  DBITS  ALU result / effective address
in_store_data  in  DBITS  rs2 value for stores
in_reg_dest  in  REGBITS  destination register
in_wr_reg  in  1  instruction writes a register
in_pc  in  DBITS  PC, passed through
in_inst  in  32  instruction word, passed through
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  DBITS  word-aligned address, low 2 bits = 0
dmem_wdata  out  32  store data, lane-replicated
dmem_wstrb  out  4  byte enables
dmem_ack  in  1  access complete; rdata valid this cycle
dmem_rdata  in  32  read word
mem_stall  out  1  AGEX and DE hold their latches
wb_valid, wb_wr_reg, wb_exc  out  1 each  MEM latch flags; wb_exc = misaligned access
wb_reg_dest  out  REGBITS  MEM latch destination
wb_data  out  DBITS  MEM latch writeback value
wb_pc  out  DBITS  MEM latch PC
wb_inst  out  32  MEM latch instruction
fwd_valid  out  1  wb_valid & wb_wr_reg & ~wb_exc
fwd_reg  out  REGBITS  equals wb_reg_dest
fwd_data  out  DBITS  equals wb_data

Behaviour:
- Reset is asynchronous, active-high. All wb_* outputs clear to 0, the FSM goes to IDLE, and dmem_req, mem_stall and the hold registers clear to 0. Outputs are 0 while reset is held.
- FSM has two states, IDLE and WAIT.
- IDLE, non-memory op, or in_valid=0:
  - MEM latch loads a pass-through on the next edge: wb_data = in_result, wb_valid = in_valid.
  - Latency is 1 cycle.
- IDLE, aligned load or store with in_valid=1:
  - Drive dmem_req=1 combinationally from the inputs and capture op, lane, dest and data into the hold registers.
  - If dmem_ack=1 in the same cycle, the access completes and the MEM latch loads on that edge.
  - If dmem_ack=0, go to WAIT and assert mem_stall=1 in that cycle and every WAIT cycle.
- WAIT: drive dmem_* from the hold registers, held stable until ack.
  - Each cycle without ack loads a bubble (wb_valid=0) into the MEM latch.
  - On dmem_ack=1: load the MEM latch with the held instruction, deassert mem_stall that cycle, return to IDLE.
  - Upstream presents the next instruction in the following cycle.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - A misaligned access makes no memory request.
  - MEM latch gets wb_valid=1, wb_exc=1, wb_wr_reg=0, wb_data=in_result.
- Load lane = addr[1:0].
  - LB/LBU take rdata[8*lane+7 : 8*lane]; LH/LHU take rdata[16*addr[1]+15 : 16*addr[1]].
  - LB and LH sign-extend; LBU and LHU zero-extend. LW takes the full word.
- Store strobes: SB = 4'b0001<<lane, SH = 4'b0011<<lane, SW = 4'b1111.
- Store wdata: SB replicates the byte ×4, SH replicates the half ×2.
- Stores force wb_wr_reg=0.
- in_reg_dest=0: wb_wr_reg is forced to 0 regardless of in_wr_reg.
- dmem_ack while not requesting is ignored.
- Reset during WAIT: the request drops immediately and the access is abandoned. The memory model must tolerate an aborted request.
- Packing: the input fields arrive packed as the AGEX latch, and the wb_* fields form `MEM_latch_WIDTH. Both layouts are defined in define.vh. The AGEX latch gains a store-data field for this block.

Decomposition:
- define.vh gains:
  - load/store op IDs: `LB_I `LH_I `LW_I `LBU_I `LHU_I `SB_I `SH_I `SW_I
  - `MEM_latch_WIDTH and `from_MEM_to_AGEX_WIDTH / `from_MEM_to_DE_WIDTH
  - FSM state encodings
- One sub-module, mem_align: a combinational lane/strobe generator plus load extractor/extender, shared by the request and response paths.

Test Plan:
- ADD passthrough: in_result=0x0000_1234, dest=5, wr_reg=1 → next cycle wb_valid=1, wb_data=0x1234, fwd_valid=1, fwd_reg=5; dmem_req stays 0.
- LW, zero-wait: addr 0x100, ack in the same cycle, rdata=0xDEAD_BEEF → wb_data=0xDEADBEEF after 1 cycle; mem_stall never asserted.
- LB with 2 wait cycles: addr 0x103, rdata=0x80xx_xxxx → mem_stall=1 for 2 cycles, dmem_addr=0x100 stable, two bubbles, then wb_data=0xFFFF_FF80.
- SH: addr 0x202, data 0x0000_ABCD → dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_wr_reg=0.
- Misaligned LW at 0x101 → dmem_req=0, wb_exc=1, wb_wr_reg=0, no stall.
- Reset in WAIT: assert reset mid-wait → dmem_req and mem_stall go to 0 immediately, wb_valid=0. After release, a fresh LW completes normally.
